// File: rtl/ad_collect.sv
// rtl/ad_collect.sv - N-channel sample collector: per-channel hold/pend, round-robin merge into a
// channel-tagged FIFO, drained through fx bus registers.

module ad_collect #(
    parameter int NCH   = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 64
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic [5:0]        dev_id,
    input  logic [NCH*DW-1:0] ad_data,
    input  logic [NCH-1:0]    ad_vld,
    input  logic [21:0]       fx_waddr,
    input  logic              fx_wr,
    input  logic [7:0]        fx_data,
    input  logic [21:0]       fx_raddr,
    input  logic              fx_rd,
    output logic [7:0]        fx_q,
    output logic              data_rdy
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int FW = 4 + DW;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_CH_EN_LO = 8'h01;
    localparam logic [7:0] REG_CH_EN_HI = 8'h02;
    localparam logic [7:0] REG_STATUS   = 8'h03;
    localparam logic [7:0] REG_LEVEL    = 8'h04;
    localparam logic [7:0] REG_OVR_LO   = 8'h05;
    localparam logic [7:0] REG_OVR_HI   = 8'h06;
    localparam logic [7:0] REG_THR      = 8'h07;
    localparam logic [7:0] REG_HEAD_CH  = 8'h08;
    localparam logic [7:0] REG_HEAD_HI  = 8'h09;
    localparam logic [7:0] REG_HEAD_LO  = 8'h0A;

    logic              enable_q, enable_d;
    logic [NCH-1:0]    ch_en_q, ch_en_d;
    logic [NCH-1:0]    ovr_q, ovr_d, ovr_set;
    logic [NCH-1:0]    pend_q, pend_d;
    logic [DW-1:0]     hold_q [NCH];
    logic [DW-1:0]     hold_d [NCH];
    logic [CW-1:0]     last_q, last_d;
    logic [7:0]        thr_q, thr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [7:0]        rdata_q, rd_val;
    logic              rdy_q, rdy_d;

    logic [FW-1:0]     mem [DEPTH];
    logic [FW-1:0]     push_word, head_word;
    logic [15:0]       head16, ch_en_rd16, ovr_rd16, ch_en_w16, ovr_clr16, count16;
    logic [3:0]        head_ch4;
    logic [7:0]        level8;

    logic              wsel, rsel, clr, pop, empty, full;
    logic [7:0]        woff, roff;
    logic              gnt_vld;
    logic [CW-1:0]     gnt_ch, cand;
    int                idx;
    logic              unused_bits;

    assign wsel  = fx_wr && (fx_waddr[21:16] == dev_id);
    assign rsel  = fx_rd && (fx_raddr[21:16] == dev_id);
    assign woff  = fx_waddr[7:0];
    assign roff  = fx_raddr[7:0];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign clr   = wsel && (woff == REG_CTRL) && fx_data[1];
    assign pop   = rsel && (roff == REG_HEAD_LO) && !empty && !clr;

    // Round-robin search starting just after the last granted channel; a clr cycle grants nothing
    // so the pending sample survives the flush.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        idx     = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            cand = CW'(idx);
            if (!gnt_vld && !full && !clr && pend_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    assign last_d    = gnt_vld ? gnt_ch : last_q;
    assign push_word = {4'(gnt_ch), hold_q[gnt_ch]};

    always_comb begin
        pend_d  = pend_q;
        ovr_set = '0;
        for (int i = 0; i < NCH; i++) begin
            hold_d[i] = hold_q[i];
            if (!(enable_q && ch_en_q[i])) begin
                pend_d[i] = 1'b0;
            end else if (ad_vld[i]) begin
                hold_d[i]  = ad_data[i*DW +: DW];
                pend_d[i]  = 1'b1;
                ovr_set[i] = pend_q[i] && !(gnt_vld && (gnt_ch == CW'(i)));
            end else if (gnt_vld && (gnt_ch == CW'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (gnt_vld) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (gnt_vld && !pop)      count_d = count_q + (AW+1)'(1);
            else if (!gnt_vld && pop) count_d = count_q - (AW+1)'(1);
        end
    end

    always_comb begin
        enable_d  = enable_q;
        thr_d     = thr_q;
        ch_en_w16 = 16'(ch_en_q);
        ovr_clr16 = '0;
        if (wsel) begin
            case (woff)
                REG_CTRL:     enable_d         = fx_data[0];
                REG_CH_EN_LO: ch_en_w16[7:0]   = fx_data;
                REG_CH_EN_HI: ch_en_w16[15:8]  = fx_data;
                REG_OVR_LO:   ovr_clr16[7:0]   = fx_data;
                REG_OVR_HI:   ovr_clr16[15:8]  = fx_data;
                REG_THR:      thr_d            = fx_data;
                default:      ;
            endcase
        end
        ch_en_d = ch_en_w16[NCH-1:0];
        // A fresh overrun in the same cycle as the clear wins so it is never lost.
        ovr_d   = (ovr_q & ~ovr_clr16[NCH-1:0]) | ovr_set;
    end

    assign rdy_d = (thr_d == 8'h00) || (16'(count_d) >= 16'(thr_d));

    always_ff @(posedge clk_sys) begin
        if (gnt_vld) mem[wr_ptr_q] <= push_word;
    end

    assign head_word  = mem[rd_ptr_q];
    assign head16     = 16'(head_word[DW-1:0]);
    assign head_ch4   = head_word[FW-1:DW];
    assign ch_en_rd16 = 16'(ch_en_q);
    assign ovr_rd16   = 16'(ovr_q);
    assign count16    = 16'(count_q);
    assign level8     = (count16 > 16'd255) ? 8'hFF : count16[7:0];

    always_comb begin
        rd_val = 8'h00;
        case (roff)
            REG_CTRL:     rd_val = {7'b0, enable_q};
            REG_CH_EN_LO: rd_val = ch_en_rd16[7:0];
            REG_CH_EN_HI: rd_val = ch_en_rd16[15:8];
            REG_STATUS:   rd_val = {6'b0, full, empty};
            REG_LEVEL:    rd_val = level8;
            REG_OVR_LO:   rd_val = ovr_rd16[7:0];
            REG_OVR_HI:   rd_val = ovr_rd16[15:8];
            REG_THR:      rd_val = thr_q;
            REG_HEAD_CH:  rd_val = empty ? 8'h00 : {4'b0, head_ch4};
            REG_HEAD_HI:  rd_val = empty ? 8'h00 : head16[15:8];
            REG_HEAD_LO:  rd_val = empty ? 8'h00 : head16[7:0];
            default:      rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            ch_en_q  <= '1;
            ovr_q    <= '0;
            pend_q   <= '0;
            last_q   <= CW'(NCH - 1);
            thr_q    <= 8'h01;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= 8'h00;
            rdy_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
        end else begin
            enable_q <= enable_d;
            ch_en_q  <= ch_en_d;
            ovr_q    <= ovr_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            thr_q    <= thr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            hold_q   <= hold_d;
            if (rsel) rdata_q <= rd_val;
        end
    end

    assign fx_q     = rdata_q;
    assign data_rdy = rdy_q;

    assign unused_bits = ^{fx_waddr[15:8], fx_raddr[15:8], ch_en_w16, ovr_clr16};

endmodule

// File: tb/tb_ad_collect.sv
// tb/tb_ad_collect.sv - directed self-checking bench for ad_collect

module tb_ad_collect;

    localparam int NCH   = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic              clk_sys  = 1'b0;
    logic              rst_n    = 1'b0;
    logic [5:0]        dev_id   = 6'h2A;
    logic [NCH*DW-1:0] ad_data  = '0;
    logic [NCH-1:0]    ad_vld   = '0;
    logic [21:0]       fx_waddr = '0;
    logic              fx_wr    = 1'b0;
    logic [7:0]        fx_data  = 8'h00;
    logic [21:0]       fx_raddr = '0;
    logic              fx_rd    = 1'b0;
    logic [7:0]        fx_q;
    logic              data_rdy;

    int checks   = 0;
    int failures = 0;

    ad_collect #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .dev_id   (dev_id),
        .ad_data  (ad_data),
        .ad_vld   (ad_vld),
        .fx_waddr (fx_waddr),
        .fx_wr    (fx_wr),
        .fx_data  (fx_data),
        .fx_raddr (fx_raddr),
        .fx_rd    (fx_rd),
        .fx_q     (fx_q),
        .data_rdy (data_rdy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic reg_wr(input logic [7:0] off, input logic [7:0] val);
        fx_waddr = {dev_id, 8'h00, off};
        fx_data  = val;
        fx_wr    = 1'b1;
        tick();
        fx_wr    = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] off, output logic [7:0] val);
        fx_raddr = {dev_id, 8'h00, off};
        fx_rd    = 1'b1;
        tick();
        fx_rd    = 1'b0;
        val      = fx_q;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [7:0] exp);
        logic [7:0] v;
        reg_rd(off, v);
        check(tag, {24'h0, v}, {24'h0, exp});
    endtask

    task automatic set_ch(input int ch, input logic [15:0] d);
        ad_data[ch*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] exp_lo;

        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_fx_q", {24'h0, fx_q}, 32'h0);
        check("rst_rdy", {31'h0, data_rdy}, 32'h0);
        rst_n = 1'b1;
        tick();
        rd_chk("rst_status", 8'h03, 8'h01);
        rd_chk("rst_chen_lo", 8'h01, 8'hFF);
        rd_chk("rst_chen_hi", 8'h02, 8'h00);
        rd_chk("rst_thr", 8'h07, 8'h01);
        rd_chk("rst_ctrl", 8'h00, 8'h00);
        rd_chk("rst_level", 8'h04, 8'h00);
        rd_chk("rst_ovr_lo", 8'h05, 8'h00);

        // single sample on channel 3
        reg_wr(8'h00, 8'h01);
        set_ch(3, 16'hBEEF);
        ad_vld = 8'h08;
        tick();
        ad_vld = '0;
        rd_chk("single_lvl_early", 8'h04, 8'h00);
        rd_chk("single_lvl", 8'h04, 8'h01);
        check("single_rdy", {31'h0, data_rdy}, 32'h1);
        rd_chk("single_ch", 8'h08, 8'h03);
        rd_chk("single_hi", 8'h09, 8'hBE);
        rd_chk("single_lo", 8'h0A, 8'hEF);
        rd_chk("single_lvl_after", 8'h04, 8'h00);
        rd_chk("single_status", 8'h03, 8'h01);
        check("single_rdy_after", {31'h0, data_rdy}, 32'h0);

        // fairness: two full bursts, then a rotation-sensitive pair
        do_reset();
        reg_wr(8'h00, 8'h01);
        for (int i = 0; i < NCH; i++) set_ch(i, 16'h00A0 + 16'(i));
        ad_vld = 8'hFF;
        tick();
        ad_vld = '0;
        repeat (9) tick();
        for (int i = 0; i < NCH; i++) set_ch(i, 16'h00B0 + 16'(i));
        ad_vld = 8'hFF;
        tick();
        ad_vld = '0;
        repeat (9) tick();
        rd_chk("fair_level", 8'h04, 8'h10);
        for (int j = 0; j < 2*NCH; j++) begin
            exp_lo = (j < NCH) ? 8'hA0 : 8'hB0;
            rd_chk($sformatf("fair_ch%0d", j), 8'h08, 8'(j % NCH));
            rd_chk($sformatf("fair_lo%0d", j), 8'h0A, exp_lo + 8'(j % NCH));
        end
        set_ch(1, 16'h0011);
        ad_vld = 8'h02;
        tick();
        ad_vld = '0;
        repeat (3) tick();
        set_ch(0, 16'h0020);
        set_ch(2, 16'h0022);
        ad_vld = 8'h05;
        tick();
        ad_vld = '0;
        repeat (4) tick();
        rd_chk("rr_ch_a", 8'h08, 8'h01);
        rd_chk("rr_lo_a", 8'h0A, 8'h11);
        rd_chk("rr_ch_b", 8'h08, 8'h02);
        rd_chk("rr_lo_b", 8'h0A, 8'h22);
        rd_chk("rr_ch_c", 8'h08, 8'h00);
        rd_chk("rr_lo_c", 8'h0A, 8'h20);

        // overrun: channel 5 disabled, fill with channel 0, then double-strobe channel 2
        reg_wr(8'h01, 8'hDF);
        for (int n = 0; n < DEPTH; n++) begin
            set_ch(0, 16'(n));
            set_ch(5, 16'hDEAD);
            ad_vld = 8'h21;
            tick();
        end
        ad_vld = '0;
        tick();
        rd_chk("ovr_level_full", 8'h04, 8'h40);
        rd_chk("ovr_status_full", 8'h03, 8'h02);
        set_ch(2, 16'h1234);
        ad_vld = 8'h04;
        tick();
        set_ch(2, 16'h5678);
        tick();
        ad_vld = '0;
        rd_chk("ovr_lo", 8'h05, 8'h04);
        rd_chk("ovr_hi", 8'h06, 8'h00);
        rd_chk("ovr_status", 8'h03, 8'h02);
        reg_wr(8'h05, 8'h04);
        rd_chk("ovr_cleared", 8'h05, 8'h00);
        for (int j = 0; j <= DEPTH; j++) begin
            rd_chk($sformatf("drain_ch%0d", j), 8'h08, (j < DEPTH) ? 8'h00 : 8'h02);
            rd_chk($sformatf("drain_lo%0d", j), 8'h0A, (j < DEPTH) ? 8'(j) : 8'h78);
        end
        rd_chk("drain_level", 8'h04, 8'h00);
        reg_wr(8'h01, 8'hFF);

        // threshold
        reg_wr(8'h07, 8'h03);
        set_ch(0, 16'h0030);
        set_ch(1, 16'h0031);
        set_ch(2, 16'h0032);
        ad_vld = 8'h07;
        tick();
        ad_vld = '0;
        check("thr_rdy_p0", {31'h0, data_rdy}, 32'h0);
        tick();
        check("thr_rdy_l1", {31'h0, data_rdy}, 32'h0);
        tick();
        check("thr_rdy_l2", {31'h0, data_rdy}, 32'h0);
        tick();
        check("thr_rdy_l3", {31'h0, data_rdy}, 32'h1);
        rd_chk("thr_level", 8'h04, 8'h03);
        rd_chk("thr_pop0", 8'h0A, 8'h30);
        check("thr_rdy_fall", {31'h0, data_rdy}, 32'h0);
        rd_chk("thr_pop1", 8'h0A, 8'h31);
        rd_chk("thr_pop2", 8'h0A, 8'h32);
        reg_wr(8'h07, 8'h00);
        check("thr_zero_rdy", {31'h0, data_rdy}, 32'h1);
        reg_wr(8'h07, 8'h01);
        check("thr_one_empty", {31'h0, data_rdy}, 32'h0);

        // boundaries
        rd_chk("pop_empty", 8'h0A, 8'h00);
        rd_chk("pop_empty_lvl", 8'h04, 8'h00);
        fx_waddr = {dev_id, 8'h00, 8'h07};
        fx_raddr = {dev_id, 8'h00, 8'h07};
        fx_data  = 8'h05;
        fx_wr    = 1'b1;
        fx_rd    = 1'b1;
        tick();
        fx_wr    = 1'b0;
        fx_rd    = 1'b0;
        check("rw_same_old", {24'h0, fx_q}, 32'h01);
        rd_chk("rw_same_new", 8'h07, 8'h05);
        reg_wr(8'h07, 8'h01);
        fx_waddr = {6'h15, 8'h00, 8'h07};
        fx_data  = 8'h09;
        fx_wr    = 1'b1;
        tick();
        fx_wr    = 1'b0;
        rd_chk("other_dev_wr", 8'h07, 8'h01);
        rd_chk("unmapped", 8'h20, 8'h00);

        set_ch(0, 16'h0042);
        ad_vld = 8'h01;
        repeat (5) tick();
        reg_wr(8'h00, 8'h03);
        rd_chk("clr_level", 8'h04, 8'h00);
        ad_vld = '0;
        rd_chk("clr_selfclear", 8'h00, 8'h01);

        // async reset mid-burst
        ad_vld = 8'hFF;
        rd_chk("prerst_ctrl", 8'h00, 8'h01);
        tick();
        check("prerst_rdy", {31'h0, data_rdy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_fx_q", {24'h0, fx_q}, 32'h0);
        check("arst_rdy", {31'h0, data_rdy}, 32'h0);
        ad_vld = '0;
        tick();
        rst_n = 1'b1;
        tick();
        rd_chk("arst_status", 8'h03, 8'h01);
        rd_chk("arst_level", 8'h04, 8'h00);
        rd_chk("arst_ctrl", 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
